// File: rtl/data_memory.sv
// data_memory: unified program/data memory behind the CPU's MAR/MDR interface.
// Words 0..7 hold the operand register file, the program starts at 8 and the
// stack grows down from the top. After reset a sequencer zeroes every word,
// one per cycle, before ready lets the CPU start.
// Optional feature macro: DATA_MEMORY_LOAD_PORT_EN adds a preload write port
// (ld_we/ld_addr/ld_data) that takes priority over the CPU write path.
module data_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
`ifdef DATA_MEMORY_LOAD_PORT_EN
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
`endif
    output logic [DATA_WIDTH-1:0] mem,
    output logic                  ready,
    output logic                  err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Clear pointer carries one spare bit so the last clear address never
    // aliases with the starting value.
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH:0]     clr_ptr_q;
    logic [DATA_WIDTH-1:0]   mem_q;
    logic                    ready_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   array_q [DEPTH];

    logic                    wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_d;
    logic [DATA_WIDTH-1:0]   mem_d;
    logic                    err_d;

    // Select the single array write for this cycle and the write-first read value.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = addr;
        wr_data_d = data;
        mem_d     = array_q[addr];
        err_d     = err_q;
        if (state_q == S_CLEAR) begin
            // Sequencer owns the array; any external write attempt is flagged and dropped.
            wr_en_d   = 1'b1;
            wr_addr_d = clr_ptr_q[ADDR_WIDTH-1:0];
            wr_data_d = '0;
            mem_d     = '0;
            if (we) err_d = 1'b1;
`ifdef DATA_MEMORY_LOAD_PORT_EN
            if (ld_we) err_d = 1'b1;
`endif
        end else begin
`ifdef DATA_MEMORY_LOAD_PORT_EN
            if (ld_we) begin
                // Loader wins a collision; the CPU write is dropped and flagged.
                wr_en_d   = 1'b1;
                wr_addr_d = ld_addr;
                wr_data_d = ld_data;
                if (we) err_d = 1'b1;
                if (ld_addr == addr) mem_d = ld_data;
            end else if (we) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr;
                wr_data_d = data;
                mem_d     = data;
            end
`else
            if (we) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr;
                wr_data_d = data;
                mem_d     = data;
            end
`endif
        end
    end

    // CLEAR -> RUN sequencer, array write and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
            mem_q     <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (wr_en_d) array_q[wr_addr_d] <= wr_data_d;
            mem_q <= mem_d;
            err_q <= err_d;
            if (state_q == S_CLEAR) begin
                clr_ptr_q <= clr_ptr_q + PTR_ONE;
                if (clr_ptr_q == PTR_LAST) begin
                    state_q <= S_RUN;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    assign mem   = mem_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed table vectors, hand-written CLEAR corner cases and
// randomized traffic, all checked every cycle against a behavioural model.
module tb_data_memory;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [DW-1:0] mem;
    logic          ready;
    logic          err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Behavioural model: cycles since reset decide CLEAR vs RUN.
    logic [DW-1:0] m_arr [DEPTH];
    int            m_cyc = 0;
    logic [DW-1:0] m_mem = '0;
    logic          m_ready = 1'b0;
    logic          m_err = 1'b0;

    always #5 clk = ~clk;

    data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .addr   (addr),
        .data   (data),
`ifdef DATA_MEMORY_LOAD_PORT_EN
        .ld_we  (ld_we),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
`endif
        .mem    (mem),
        .ready  (ready),
        .err    (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: update the model from the applied inputs, then compare outputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cyc = 0; m_mem = '0; m_ready = 1'b0; m_err = 1'b0;
        end else if (m_cyc < DEPTH) begin
            m_arr[m_cyc] = '0;
            if (we || ld_we) m_err = 1'b1;
            m_cyc++;
            m_mem = '0;
        end else begin
            if (ld_we) m_arr[ld_addr] = ld_data;
            if (we) begin
                if (ld_we) m_err = 1'b1;
                else       m_arr[addr] = data;
            end
            m_mem = m_arr[addr];
        end
        m_ready = (m_cyc >= DEPTH);
        #1;
        chk("model_mem", {16'h0, mem}, {16'h0, m_mem});
        chk("model_ready", {31'h0, ready}, {31'h0, m_ready});
        chk("model_err", {31'h0, err}, {31'h0, m_err});
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [7];
    int   n;

    initial begin
        // Write-first, hold, top/bottom boundary without aliasing.
        tbl[0] = '{1'b1, 6'd8,  16'hA5A5, 16'hA5A5};
        tbl[1] = '{1'b0, 6'd8,  16'h0000, 16'hA5A5};
        tbl[2] = '{1'b1, 6'd63, 16'h1234, 16'h1234};
        tbl[3] = '{1'b1, 6'd0,  16'h5678, 16'h5678};
        tbl[4] = '{1'b0, 6'd63, 16'hFFFF, 16'h1234};
        tbl[5] = '{1'b0, 6'd0,  16'hFFFF, 16'h5678};
        tbl[6] = '{1'b0, 6'd8,  16'h0000, 16'hA5A5};

        // Reset for 2 cycles, then the clear sequence.
        rst = 1'b1;
        tick(); tick();
        chk("reset_mem", {16'h0, mem}, 32'h0);
        chk("reset_ready", {31'h0, ready}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("clear_ready", {31'h0, ready}, (i == DEPTH - 1) ? 32'h1 : 32'h0);
        end
        chk("clear_err", {31'h0, err}, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            addr = AW'(i);
            tick();
            chk("cleared_word", {16'h0, mem}, 32'h0);
        end

        // Table-driven RUN vectors.
        for (int i = 0; i < 7; i++) begin
            we = tbl[i].we; addr = tbl[i].addr; data = tbl[i].data;
            tick();
            chk("table_mem", {16'h0, mem}, {16'h0, tbl[i].exp});
        end
        we = 1'b0;

        // CPU write during CLEAR is flagged and dropped.
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        we = 1'b1; addr = 6'd3; data = 16'hFFFF;
        tick();
        we = 1'b0;
        chk("clear_we_err", {31'h0, err}, 32'h1);
        for (int i = 11; i < DEPTH; i++) tick();
        chk("clear_we_ready", {31'h0, ready}, 32'h1);
        chk("clear_we_sticky", {31'h0, err}, 32'h1);
        addr = 6'd3;
        tick();
        chk("clear_we_word", {16'h0, mem}, 32'h0);

        // Reset mid-CLEAR restarts the full clear and clears err.
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("restart_latency", n, 32'd64);
        chk("restart_err", {31'h0, err}, 32'h0);

`ifdef DATA_MEMORY_LOAD_PORT_EN
        // Loader and CPU write collide: load wins, CPU write dropped.
        ld_we = 1'b1; ld_addr = 6'd5; ld_data = 16'h00FF;
        we = 1'b1; addr = 6'd6; data = 16'hBEEF;
        tick();
        ld_we = 1'b0; we = 1'b0;
        chk("ld_collide_err", {31'h0, err}, 32'h1);
        addr = 6'd5; tick();
        chk("ld_word5", {16'h0, mem}, 32'h00FF);
        addr = 6'd6; tick();
        chk("ld_word6", {16'h0, mem}, 32'h0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            we   = 1'($urandom_range(0, 1));
            addr = AW'($urandom_range(0, DEPTH - 1));
            data = DW'($urandom);
`ifdef DATA_MEMORY_LOAD_PORT_EN
            ld_we   = ($urandom_range(0, 3) == 0);
            ld_addr = ($urandom_range(0, 1) == 0) ? addr : AW'($urandom_range(0, DEPTH - 1));
            ld_data = DW'($urandom);
`endif
            tick();
        end
        rst = 1'b0; we = 1'b0; ld_we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
